// File: rtl/jtframe_ram16_share.sv
// rtl/jtframe_ram16_share.sv - time-shares one 16-bit byte-writable RAM between a R/W port and a read-only port
module jtframe_ram16_share #(
  parameter int AW = 10,
  parameter bit RR = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  input  logic [15:0]   a_din,
  input  logic [1:0]    a_we,
  output logic [15:0]   a_dout,
  output logic          a_ok,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic [15:0]   b_dout,
  output logic          b_ok,
  output logic [AW-1:0] ram_addr,
  output logic [15:0]   ram_data,
  output logic [1:0]    ram_we,
  input  logic [15:0]   ram_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0] st;
  logic       gnt_b;   // port owning the access in flight
  logic       last_b;  // port served most recently
  logic       wr;      // access in flight is an A write
  logic       done_a, done_b;
  logic       pend_a, pend_b;
  logic       sel_b;

  assign pend_a = a_cs & ~done_a;
  assign pend_b = b_cs & ~done_b;

  always_comb begin
    sel_b = 1'b0;
    if (pend_a && pend_b)
      sel_b = RR ? ~last_b : 1'b0;
    else
      sel_b = pend_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      gnt_b    <= 1'b0;
      last_b   <= 1'b1;
      wr       <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      a_ok     <= 1'b0;
      b_ok     <= 1'b0;
      a_dout   <= 16'd0;
      b_dout   <= 16'd0;
      ram_addr <= '0;
      ram_data <= 16'd0;
      ram_we   <= 2'd0;
    end else begin
      a_ok <= 1'b0;
      b_ok <= 1'b0;
      if (!a_cs) done_a <= 1'b0;
      if (!b_cs) done_b <= 1'b0;
      case (st)
        IDLE: begin
          if (pend_a || pend_b) begin
            gnt_b <= sel_b;
            st    <= ACC;
            if (sel_b) begin
              ram_addr <= b_addr;
              ram_we   <= 2'd0;
              wr       <= 1'b0;
            end else begin
              ram_addr <= a_addr;
              ram_data <= a_din;
              ram_we   <= a_we;
              wr       <= |a_we;
            end
          end
        end
        ACC: begin
          ram_we <= 2'd0;
          st     <= WAIT;
        end
        WAIT: begin
          // done is set after the cs-low clear so the completion always sticks
          if (gnt_b) begin
            b_dout <= ram_q;
            b_ok   <= 1'b1;
            done_b <= 1'b1;
          end else begin
            if (!wr) a_dout <= ram_q;
            a_ok   <= 1'b1;
            done_a <= 1'b1;
          end
          last_b <= gnt_b;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_ram16_share.sv
// tb/tb_jtframe_ram16_share.sv - directed bench for jtframe_ram16_share, round-robin and fixed-priority instances
module tb_jtframe_ram16_share;

  logic        rst = 1'b1;
  logic        clk = 1'b0;
  logic        a_cs = 1'b0;
  logic [9:0]  a_addr = '0;
  logic [15:0] a_din = '0;
  logic [1:0]  a_we = '0;
  logic        b_cs = 1'b0;
  logic [9:0]  b_addr = '0;

  logic [15:0] a_dout, b_dout, ram_data, ram_q;
  logic        a_ok, b_ok;
  logic [9:0]  ram_addr;
  logic [1:0]  ram_we;

  logic [15:0] a_dout_f, b_dout_f, ram_data_f, ram_q_f;
  logic        a_ok_f, b_ok_f;
  logic [9:0]  ram_addr_f;
  logic [1:0]  ram_we_f;

  logic [15:0] mem   [0:1023];
  logic [15:0] mem_f [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_ram16_share #(.AW(10), .RR(1'b1)) dut (
    .rst(rst), .clk(clk),
    .a_cs(a_cs), .a_addr(a_addr), .a_din(a_din), .a_we(a_we),
    .a_dout(a_dout), .a_ok(a_ok),
    .b_cs(b_cs), .b_addr(b_addr), .b_dout(b_dout), .b_ok(b_ok),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  jtframe_ram16_share #(.AW(10), .RR(1'b0)) dut_f (
    .rst(rst), .clk(clk),
    .a_cs(a_cs), .a_addr(a_addr), .a_din(a_din), .a_we(a_we),
    .a_dout(a_dout_f), .a_ok(a_ok_f),
    .b_cs(b_cs), .b_addr(b_addr), .b_dout(b_dout_f), .b_ok(b_ok_f),
    .ram_addr(ram_addr_f), .ram_data(ram_data_f), .ram_we(ram_we_f), .ram_q(ram_q_f)
  );

  // registered-read, byte-writable RAM behind each instance
  always @(posedge clk) begin
    if (ram_we[0]) mem[ram_addr][7:0]  <= ram_data[7:0];
    if (ram_we[1]) mem[ram_addr][15:8] <= ram_data[15:8];
    ram_q <= mem[ram_addr];
    if (ram_we_f[0]) mem_f[ram_addr_f][7:0]  <= ram_data_f[7:0];
    if (ram_we_f[1]) mem_f[ram_addr_f][15:8] <= ram_data_f[15:8];
    ram_q_f <= mem_f[ram_addr_f];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("ok_excl_rr", {31'd0, a_ok & b_ok}, 32'd0);
      check("ok_excl_fp", {31'd0, a_ok_f & b_ok_f}, 32'd0);
    end
  end

  task automatic acc_a(input logic [9:0] addr, input logic [15:0] din, input logic [1:0] we,
                       input logic [15:0] exp_dout, input string tag);
    a_cs = 1'b1; a_addr = addr; a_din = din; a_we = we;
    tick;
    check({tag, "_we"}, {30'd0, ram_we}, {30'd0, we});
    check({tag, "_addr"}, {22'd0, ram_addr}, {22'd0, addr});
    if (we != 2'd0) check({tag, "_data"}, {16'd0, ram_data}, {16'd0, din});
    check({tag, "_ok1"}, {31'd0, a_ok}, 32'd0);
    tick;
    check({tag, "_we2"}, {30'd0, ram_we}, 32'd0);
    check({tag, "_ok2"}, {31'd0, a_ok}, 32'd0);
    tick;
    check({tag, "_ok3"}, {31'd0, a_ok}, 32'd1);
    check({tag, "_dout"}, {16'd0, a_dout}, {16'd0, exp_dout});
    a_cs = 1'b0;
    tick;
  endtask

  task automatic acc_b(input logic [9:0] addr, input logic [15:0] exp_dout, input string tag);
    b_cs = 1'b1; b_addr = addr;
    tick;
    check({tag, "_we"}, {30'd0, ram_we}, 32'd0);
    check({tag, "_addr"}, {22'd0, ram_addr}, {22'd0, addr});
    tick;
    check({tag, "_ok2"}, {31'd0, b_ok}, 32'd0);
    tick;
    check({tag, "_ok3"}, {31'd0, b_ok}, 32'd1);
    check({tag, "_dout"}, {16'd0, b_dout}, {16'd0, exp_dout});
    b_cs = 1'b0;
    tick;
  endtask

  // both ports request together; A reads 0x012 (0xBEEF), B reads 0x005 (0x1256)
  task automatic pair(input logic b_first, input string tag);
    a_cs = 1'b1; a_addr = 10'h012; a_we = 2'd0;
    b_cs = 1'b1; b_addr = 10'h005;
    repeat (3) tick;
    check({tag, "_rr_a3"}, {31'd0, a_ok}, {31'd0, ~b_first});
    check({tag, "_rr_b3"}, {31'd0, b_ok}, {31'd0, b_first});
    check({tag, "_fp_a3"}, {31'd0, a_ok_f}, 32'd1);
    check({tag, "_fp_b3"}, {31'd0, b_ok_f}, 32'd0);
    repeat (3) tick;
    check({tag, "_rr_a6"}, {31'd0, a_ok}, {31'd0, b_first});
    check({tag, "_rr_b6"}, {31'd0, b_ok}, {31'd0, ~b_first});
    check({tag, "_fp_a6"}, {31'd0, a_ok_f}, 32'd0);
    check({tag, "_fp_b6"}, {31'd0, b_ok_f}, 32'd1);
    check({tag, "_rr_adout"}, {16'd0, a_dout}, 32'h0000_BEEF);
    check({tag, "_rr_bdout"}, {16'd0, b_dout}, 32'h0000_1256);
    check({tag, "_fp_adout"}, {16'd0, a_dout_f}, 32'h0000_BEEF);
    check({tag, "_fp_bdout"}, {16'd0, b_dout_f}, 32'h0000_1256);
    a_cs = 1'b0; b_cs = 1'b0;
    tick;
  endtask

  initial begin
    int ok_cnt;
    int we_cnt;

    rst = 1'b1;
    repeat (3) tick;
    check("rst_a_ok", {31'd0, a_ok}, 32'd0);
    check("rst_b_ok", {31'd0, b_ok}, 32'd0);
    check("rst_a_dout", {16'd0, a_dout}, 32'd0);
    check("rst_b_dout", {16'd0, b_dout}, 32'd0);
    check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("rst_ram_data", {16'd0, ram_data}, 32'd0);
    check("rst_ram_we", {30'd0, ram_we}, 32'd0);
    rst = 1'b0;
    tick;

    acc_a(10'h012, 16'hBEEF, 2'b11, 16'h0000, "wr_beef");
    acc_a(10'h012, 16'h0000, 2'b00, 16'hBEEF, "rd_beef");

    acc_a(10'h005, 16'h1234, 2'b11, 16'hBEEF, "wr_1234");
    acc_a(10'h005, 16'hAB56, 2'b01, 16'hBEEF, "wr_lo56");
    acc_b(10'h005, 16'h1256, "b_lanes");

    pair(1'b0, "pair1");
    acc_a(10'h012, 16'h0000, 2'b00, 16'hBEEF, "a_solo");
    pair(1'b1, "pair2");

    ok_cnt = 0;
    we_cnt = 0;
    b_cs = 1'b1; b_addr = 10'h012;
    repeat (20) begin
      tick;
      if (b_ok) ok_cnt++;
      if (ram_we != 2'd0) we_cnt++;
    end
    check("held_ok_cnt", ok_cnt, 32'd1);
    check("held_we_cnt", we_cnt, 32'd0);
    check("held_dout", {16'd0, b_dout}, 32'h0000_BEEF);
    b_cs = 1'b0;
    tick;

    a_cs = 1'b1; a_addr = 10'h3FF; a_din = 16'h00FF; a_we = 2'b11;
    tick;
    a_cs = 1'b0;
    check("abort_we", {30'd0, ram_we}, 32'd3);
    tick;
    tick;
    check("abort_ok", {31'd0, a_ok}, 32'd1);
    tick;
    acc_a(10'h3FF, 16'h0000, 2'b00, 16'h00FF, "abort_rd");

    a_cs = 1'b1; a_addr = 10'h012; a_we = 2'b00;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("rstw_a_ok", {31'd0, a_ok}, 32'd0);
    check("rstw_a_dout", {16'd0, a_dout}, 32'd0);
    check("rstw_b_dout", {16'd0, b_dout}, 32'd0);
    check("rstw_ram_addr", {22'd0, ram_addr}, 32'd0);
    check("rstw_ram_we", {30'd0, ram_we}, 32'd0);
    a_cs = 1'b0;
    tick;
    check("rstw_no_ok", {31'd0, a_ok}, 32'd0);
    #2;
    rst = 1'b0;
    acc_a(10'h012, 16'h0000, 2'b00, 16'hBEEF, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
